data_assembler: RTL and testbench
=================================

Name: data_assembler

Overview:
Receive-side counterpart of the output packer.
- Collects a stream of USBDW-wide beats from the USB/FT245 interface, most-significant beat first.
- Reassembles the beats into OW-wide words for the FPGA processing chain (config/command path and loopback check).
- Provides beat framing, resynchronisation and inter-beat gap timeout, so a lost beat cannot permanently misalign the word boundary.

Parameters:
- OW, 16, output word width; must be an integer multiple of USBDW, with OW/USBDW >= 2.
- USBDW, 8, input beat width.
- GAP_TIMEOUT, 255, idle cycles allowed between beats of one word before the partial word is dropped; 0 disables the timeout.
- DROPW, 8, width of the saturating drop counter.

Ports:
- clk_i  input  1  system clock, single clock domain.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  data_i carries a beat this cycle.
- data_i  input  USBDW  input beat.
- sync_i  input  1  word-boundary marker: discard any partial word; a beat presented in the same cycle is beat 0.
- data_o  output  OW  assembled word, held until the next completed word.
- valid_o  output  1  one-cycle pulse, data_o updated.
- drop_o  output  1  one-cycle pulse, partial word discarded (by timeout or by sync_i).
- drop_cnt_o  output  DROPW  saturating count of drop_o pulses.

Behaviour:
- Constant NBEAT = OW/USBDW. Internal state:
  - beat counter, 0..NBEAT-1;
  - shift register, (NBEAT-1)*USBDW bits;
  - gap counter, wide enough for GAP_TIMEOUT.
- Reset, asynchronous on rst_i high: data_o=0, valid_o=0, drop_o=0, drop_cnt_o=0, beat counter=0, shift register=0, gap counter=0. Reset mid-word discards the partial word without a drop_o pulse.
- States: IDLE (beat counter == 0) and FILL (beat counter > 0). There is no separate state register.
- IDLE:
  - valid_i=1: shift in data_i, beat counter -> 1, go to FILL.
  - otherwise: hold.
- FILL, valid_i=1 and beat counter < NBEAT-1:
  - shift register <= {shift[lower bits], data_i};
  - beat counter increments;
  - gap counter cleared.
- FILL, valid_i=1 and beat counter == NBEAT-1:
  - data_o <= {shift register, data_i};
  - valid_o=1 in the next cycle;
  - beat counter -> 0 (IDLE).
  - Latency: one clock edge from the final beat to valid_o/data_o.
- Beat order: the first beat lands in data_o[OW-1:OW-USBDW] and the last beat in data_o[USBDW-1:0]. This is the exact inverse of the packer (upper half first).
- Back-to-back words with valid_i high every cycle are supported at full rate: valid_o pulses every NBEAT cycles, with no bubble.
- Gap timeout (GAP_TIMEOUT > 0):
  - In FILL with valid_i=0, the gap counter increments.
  - When it reaches GAP_TIMEOUT: beat counter -> 0, gap counter -> 0, drop_o=1 next cycle.
  - The counter is held at 0 in IDLE.
- sync_i=1 overrides the beat counter:
  - In FILL, the partial word is discarded, with a drop_o pulse and a drop_cnt_o increment.
  - In IDLE, no drop is signalled.
  - If valid_i=1 in the same cycle, data_i becomes beat 0 and the beat counter -> 1. Otherwise the beat counter -> 0.
  - sync_i with NBEAT=... never completes a word in the same cycle.
- Simultaneous events:
  - Timeout expiry in the same cycle as valid_i: valid_i wins and the gap counter is cleared.
  - sync_i in the same cycle as a would-be final beat: sync_i wins, and no valid_o is produced.
- drop_cnt_o increments on each drop and saturates at 2^DROPW-1.
- data_o is unchanged on drop and on sync.

Decomposition:
- NBEAT and the width-check constant belong in fmcw_defines.vh, alongside OW and USBDW.
- Elaboration-time check: OW % USBDW == 0, otherwise $error.
- No sub-module; the gap counter is small enough to stay inline. If reuse is wanted, a sat_counter sub-module for drop_cnt_o is acceptable.

Test Plan:
- Reset, then beats 0xAB, 0xCD on consecutive cycles -> one cycle after the second beat, data_o=0xABCD and valid_o=1 for exactly one cycle. drop_o stays 0.
- 8 back-to-back beats 0x01..0x08 -> valid_o pulses every 2 cycles, with data_o=0x0102, 0x0304, 0x0506, 0x0708.
- Beat 0x11, then 255 idle cycles, then 0x22, 0x33 -> drop_o pulses once, drop_cnt_o=1, next word data_o=0x2233. With 254 idle cycles instead: no drop, word 0x1122.
- Beat 0xAA, then beat 0xBB with sync_i=1, then 0xCC -> drop_o=1, data_o=0xBBCC. No word containing 0xAA is produced.
- OW=32, USBDW=8: beats 0xDE 0xAD 0xBE 0xEF -> data_o=0xDEADBEEF. rst_i asserted after 2 beats -> outputs are 0 immediately (asynchronous), and the next 4 beats form a fresh word.
- Force 300 sync-drops with DROPW=8 -> drop_cnt_o saturates at 255.

Source files
------------

// File: rtl/data_assembler_pkg.sv
// Shared types and elaboration helpers for the receive-side beat assembler.
// Word fill state is decoded from the beat counter and is not stored separately.
package data_assembler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/data_assembler.sv
// Reassembles USBDW-wide beats (most-significant beat first) into OW-wide words,
// with sync-based resynchronisation, inter-beat gap timeout and a saturating drop count.
module data_assembler
  import data_assembler_pkg::*;
#(
  parameter int unsigned OW          = 16,
  parameter int unsigned USBDW       = 8,
  parameter int unsigned GAP_TIMEOUT = 255,
  parameter int unsigned DROPW       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [USBDW-1:0] data_i,
  input  logic             sync_i,
  output logic [OW-1:0]    data_o,
  output logic             valid_o,
  output logic             drop_o,
  output logic [DROPW-1:0] drop_cnt_o
);

  localparam int unsigned NBEAT = OW / USBDW;
  localparam int unsigned SW    = (NBEAT - 1) * USBDW;
  localparam int unsigned BW    = width_of(NBEAT - 1);
  localparam int unsigned GW    = width_of(GAP_TIMEOUT);

  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TIMEOUT > 0) ? (GAP_TIMEOUT - 1) : 0);

  generate
    if (OW % USBDW != 0) begin : g_bad_ratio
      $error("data_assembler: OW (%0d) must be a multiple of USBDW (%0d)", OW, USBDW);
    end
    if (OW / USBDW < 2) begin : g_bad_nbeat
      $error("data_assembler: OW/USBDW must be at least 2");
    end
  endgenerate

  function automatic logic [DROPW-1:0] sat_inc(input logic [DROPW-1:0] val);
    if (&val) return val;
    return val + 1'b1;
  endfunction

  logic [BW-1:0]    beat_cnt, beat_nxt;
  logic [SW-1:0]    shift_reg, shift_nxt, shift_in;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic [OW-1:0]    word_p1, word_nxt;
  logic             vld_p1, vld_nxt;
  logic             drop_p1, drop_nxt;
  logic [DROPW-1:0] drop_cnt_p1;
  fill_state_t      state;

  assign state = (beat_cnt == '0) ? IDLE : FILL;

  // With two beats per word the shift register holds exactly one beat.
  generate
    if (NBEAT == 2) begin : g_shift_one
      assign shift_in = data_i;
    end else begin : g_shift_many
      assign shift_in = {shift_reg[SW-USBDW-1:0], data_i};
    end
  endgenerate

  always_comb begin
    beat_nxt  = beat_cnt;
    shift_nxt = shift_reg;
    gap_nxt   = gap_cnt;
    word_nxt  = word_p1;
    vld_nxt   = 1'b0;
    drop_nxt  = 1'b0;

    if (sync_i) begin
      // Resync: any partial word is abandoned and a concurrent beat becomes beat 0.
      drop_nxt = (state == FILL);
      gap_nxt  = '0;
      if (valid_i) begin
        shift_nxt = shift_in;
        beat_nxt  = BW'(1);
      end else begin
        beat_nxt  = '0;
      end
    end else if (valid_i) begin
      gap_nxt = '0;
      if (beat_cnt == LAST_BEAT) begin
        word_nxt = {shift_reg, data_i};
        vld_nxt  = 1'b1;
        beat_nxt = '0;
      end else begin
        shift_nxt = shift_in;
        beat_nxt  = beat_cnt + 1'b1;
      end
    end else if ((state == FILL) && (GAP_TIMEOUT > 0)) begin
      if (gap_cnt == GAP_LAST) begin
        beat_nxt = '0;
        gap_nxt  = '0;
        drop_nxt = 1'b1;
      end else begin
        gap_nxt  = gap_cnt + 1'b1;
      end
    end
  end

  // ---- stage p1: registered word, strobes and counters ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt    <= '0;
      shift_reg   <= '0;
      gap_cnt     <= '0;
      word_p1     <= '0;
      vld_p1      <= 1'b0;
      drop_p1     <= 1'b0;
      drop_cnt_p1 <= '0;
    end else begin
      beat_cnt  <= beat_nxt;
      shift_reg <= shift_nxt;
      gap_cnt   <= gap_nxt;
      word_p1   <= word_nxt;
      vld_p1    <= vld_nxt;
      drop_p1   <= drop_nxt;
      if (drop_nxt) drop_cnt_p1 <= sat_inc(drop_cnt_p1);
    end
  end

  assign data_o     = word_p1;
  assign valid_o    = vld_p1;
  assign drop_o     = drop_p1;
  assign drop_cnt_o = drop_cnt_p1;

endmodule

// File: tb/tb_data_assembler.sv
// Bench for data_assembler: vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based model of word assembly.
module tb_data_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16, v16, s16;
  logic [7:0]  d16;
  logic [15:0] q16;
  logic        vo16, do16;
  logic [7:0]  c16;

  logic        rst32, v32, s32;
  logic [7:0]  d32;
  logic [31:0] q32;
  logic        vo32, do32;
  logic [7:0]  c32;

  data_assembler #(.OW(16), .USBDW(8), .GAP_TIMEOUT(255), .DROPW(8)) dut16 (
    .clk_i(clk), .rst_i(rst16), .valid_i(v16), .data_i(d16), .sync_i(s16),
    .data_o(q16), .valid_o(vo16), .drop_o(do16), .drop_cnt_o(c16));

  data_assembler #(.OW(32), .USBDW(8), .GAP_TIMEOUT(255), .DROPW(8)) dut32 (
    .clk_i(clk), .rst_i(rst32), .valid_i(v32), .data_i(d32), .sync_i(s32),
    .data_o(q32), .valid_o(vo32), .drop_o(do32), .drop_cnt_o(c32));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the 16-bit instance: beats collected in a queue, word formed when two are held.
  logic [7:0]  mq[$];
  int          m_gap   = 0;
  logic [15:0] m_word  = '0;
  logic        m_vld   = 1'b0;
  logic        m_drop  = 1'b0;
  int          m_drops = 0;

  task automatic model_reset();
    mq.delete();
    m_gap = 0; m_word = '0; m_vld = 1'b0; m_drop = 1'b0; m_drops = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic s);
    m_vld = 1'b0;
    m_drop = 1'b0;
    if (s) begin
      if (mq.size() > 0) begin m_drop = 1'b1; m_drops++; end
      mq.delete();
      m_gap = 0;
      if (v) mq.push_back(d);
    end else if (v) begin
      m_gap = 0;
      mq.push_back(d);
      if (mq.size() == 2) begin
        m_word = {mq[0], mq[1]};
        m_vld = 1'b1;
        mq.delete();
      end
    end else if (mq.size() > 0) begin
      m_gap++;
      if (m_gap == 255) begin
        m_drop = 1'b1; m_drops++;
        mq.delete();
        m_gap = 0;
      end
    end
  endtask

  function automatic logic [7:0] m_cnt();
    return (m_drops > 255) ? 8'd255 : 8'(m_drops);
  endfunction

  // Drive one cycle on the 16-bit instance; outputs sampled 1 time unit after the edge.
  task automatic drive16(input logic v, input logic [7:0] d, input logic s);
    v16 = v; d16 = d; s16 = s;
    @(posedge clk);
    model_step(v, d, s);
    #1;
  endtask

  task automatic step16(input logic v, input logic [7:0] d, input logic s);
    drive16(v, d, s);
    chk("model_valid", vo16, m_vld);
    chk("model_drop", do16, m_drop);
    chk("model_cnt", c16, m_cnt());
    if (m_vld) chk("model_data", q16, m_word);
  endtask

  task automatic step32(input logic v, input logic [7:0] d);
    v32 = v; d32 = d; s32 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        s;
    logic        ev;
    logic [15:0] eq;
    logic        edrop;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{1'b1, 8'hAB, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 8'hCD, 1'b0, 1'b1, 16'hABCD, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hABCD, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 8'h01, 1'b0, 1'b0, 16'hABCD, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 8'h02, 1'b0, 1'b1, 16'h0102, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 8'h03, 1'b0, 1'b0, 16'h0102, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 8'h04, 1'b0, 1'b1, 16'h0304, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 8'h05, 1'b0, 1'b0, 16'h0304, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 8'h06, 1'b0, 1'b1, 16'h0506, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 8'h07, 1'b0, 1'b0, 16'h0506, 1'b0, 8'd0};
    vecs[10] = '{1'b1, 8'h08, 1'b0, 1'b1, 16'h0708, 1'b0, 8'd0};
    vecs[11] = '{1'b1, 8'hAA, 1'b0, 1'b0, 16'h0708, 1'b0, 8'd0};
    vecs[12] = '{1'b1, 8'hBB, 1'b1, 1'b0, 16'h0708, 1'b1, 8'd1};
    vecs[13] = '{1'b1, 8'hCC, 1'b0, 1'b1, 16'hBBCC, 1'b0, 8'd1};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hBBCC, 1'b0, 8'd1};
    vecs[15] = '{1'b1, 8'h12, 1'b1, 1'b0, 16'hBBCC, 1'b0, 8'd1};
    vecs[16] = '{1'b1, 8'h34, 1'b0, 1'b1, 16'h1234, 1'b0, 8'd1};
    vecs[17] = '{1'b1, 8'h56, 1'b0, 1'b0, 16'h1234, 1'b0, 8'd1};
    vecs[18] = '{1'b1, 8'h78, 1'b1, 1'b0, 16'h1234, 1'b1, 8'd2};
    vecs[19] = '{1'b1, 8'h9A, 1'b0, 1'b1, 16'h789A, 1'b0, 8'd2};

    rst16 = 1'b1; rst32 = 1'b1;
    v16 = 1'b0; d16 = '0; s16 = 1'b0;
    v32 = 1'b0; d32 = '0; s32 = 1'b0;
    model_reset();
    #3;
    chk("rst16_data", q16, 0);
    chk("rst16_valid", vo16, 0);
    chk("rst16_drop", do16, 0);
    chk("rst16_cnt", c16, 0);
    chk("rst32_data", q32, 0);
    chk("rst32_valid", vo32, 0);
    @(posedge clk);
    #1;
    rst16 = 1'b0; rst32 = 1'b0;

    // Vector table: basic word, back-to-back words, sync corner cases.
    for (int i = 0; i < 20; i++) begin
      drive16(vecs[i].v, vecs[i].d, vecs[i].s);
      chk($sformatf("vec%0d_valid", i), vo16, vecs[i].ev);
      chk($sformatf("vec%0d_data", i), q16, vecs[i].eq);
      chk($sformatf("vec%0d_drop", i), do16, vecs[i].edrop);
      chk($sformatf("vec%0d_cnt", i), c16, vecs[i].ecnt);
    end

    // Gap of 255 idle cycles drops the partial word.
    step16(1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 255; i++) step16(1'b0, 8'h00, 1'b0);
    chk("gap255_drop", do16, 1);
    chk("gap255_cnt", c16, 3);
    step16(1'b1, 8'h22, 1'b0);
    step16(1'b1, 8'h33, 1'b0);
    chk("gap255_word", q16, 16'h2233);
    chk("gap255_valid", vo16, 1);

    // Gap of 254 idle cycles keeps the partial word.
    step16(1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 254; i++) step16(1'b0, 8'h00, 1'b0);
    chk("gap254_nodrop", do16, 0);
    step16(1'b1, 8'h22, 1'b0);
    chk("gap254_word", q16, 16'h1122);
    chk("gap254_valid", vo16, 1);
    chk("gap254_cnt", c16, 3);

    // 32-bit instance: full word, then asynchronous reset mid-word.
    step32(1'b1, 8'hDE);
    step32(1'b1, 8'hAD);
    step32(1'b1, 8'hBE);
    chk("w32_novalid_early", vo32, 0);
    step32(1'b1, 8'hEF);
    chk("w32_data", q32, 32'hDEADBEEF);
    chk("w32_valid", vo32, 1);
    step32(1'b1, 8'h11);
    chk("w32_pulse_one", vo32, 0);
    step32(1'b1, 8'h22);
    v32 = 1'b0;
    #2;
    rst32 = 1'b1;
    #1;
    chk("w32_async_rst_data", q32, 0);
    chk("w32_async_rst_cnt", c32, 0);
    chk("w32_async_rst_drop", do32, 0);
    @(posedge clk);
    #1;
    rst32 = 1'b0;
    step32(1'b1, 8'h01);
    step32(1'b1, 8'h02);
    step32(1'b1, 8'h03);
    chk("w32_fresh_partial", vo32, 0);
    step32(1'b1, 8'h04);
    chk("w32_fresh_data", q32, 32'h01020304);
    chk("w32_fresh_valid", vo32, 1);
    chk("w32_fresh_nodrop_cnt", c32, 0);
    step32(1'b0, 8'h00);

    // Randomized traffic against the model, with occasional long idle runs.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) == 0) begin
        int n;
        n = $urandom_range(260, 250);
        for (int k = 0; k < n; k++) step16(1'b0, 8'h00, 1'b0);
      end else begin
        step16($urandom_range(9) < 7, 8'($urandom), $urandom_range(19) == 0);
      end
    end

    // Drive enough sync drops to saturate the counter.
    for (int i = 0; i < 300; i++) begin
      step16(1'b1, 8'($urandom), 1'b0);
      step16(1'b0, 8'h00, 1'b1);
    end
    chk("sat_cnt", c16, 8'd255);
    step16(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
